// File: rtl/leaf_port_bridge.sv
// leaf_port_bridge
//   Per-page adapter between leaf_interface word ports (vld/ack, PAYLOAD_BITS)
//   and an HLS kernel's AXI-stream ports (USER_BITS = PAYLOAD_BITS*USER_WORDS).
//   Input channels gather USER_WORDS words into one kernel beat; output channels
//   scatter one kernel beat into USER_WORDS words. Each channel buffers up to
//   FIFO_DEPTH beats. All ready/ack outputs depend only on registered state.
// Ports:
//   clk, reset (async, active-high), flush (sync clear of all channel state)
//   dout_leaf_interface2user / vld_interface2user / ack_user2interface : BFT->bridge words
//   user_in_tdata / user_in_tvalid / user_in_tready                     : bridge->kernel beats
//   user_out_tdata / user_out_tvalid / user_out_tready                  : kernel->bridge beats
//   din_leaf_user2interface / vld_user2interface / ack_interface2user   : bridge->BFT words
module leaf_port_bridge #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int USER_WORDS    = 1,
  parameter int NUM_IN_PORTS  = 1,
  parameter int NUM_OUT_PORTS = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]         dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]                      vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]                      ack_user2interface,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]        din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                     vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                     ack_interface2user,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS*USER_WORDS-1:0]  user_in_tdata,
  output logic [NUM_IN_PORTS-1:0]                      user_in_tvalid,
  input  logic [NUM_IN_PORTS-1:0]                      user_in_tready,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS*USER_WORDS-1:0] user_out_tdata,
  input  logic [NUM_OUT_PORTS-1:0]                     user_out_tvalid,
  output logic [NUM_OUT_PORTS-1:0]                     user_out_tready,
  input  logic                                         flush
);

  localparam int USER_BITS = PAYLOAD_BITS * USER_WORDS;
  localparam int IDX_W     = (USER_WORDS > 1) ? $clog2(USER_WORDS) : 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(USER_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------- gather
  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [USER_BITS-1:0]    gather_q, gather_d;
    logic [USER_BITS-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PAYLOAD_BITS-1:0] word_s;
    logic [USER_BITS-1:0]    beat_s;
    logic                    full_s, empty_s, last_s, ack_s, acc_s, push_s, pop_s;

    assign word_s  = dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign full_s  = (cnt_q == CNT_FULL);
    assign empty_s = (cnt_q == {CNT_W{1'b0}});
    assign last_s  = (idx_q == IDX_LAST);
    // Only the closing word of a beat needs FIFO space; ack is forced low in reset.
    assign ack_s   = ~reset & (~last_s | ~full_s);
    assign acc_s   = vld_interface2user[i] & ack_s & ~flush;
    assign push_s  = acc_s & last_s;
    assign pop_s   = ~empty_s & user_in_tready[i] & ~flush;

    assign ack_user2interface[i]                    = ack_s;
    assign user_in_tvalid[i]                        = ~empty_s;
    assign user_in_tdata[i*USER_BITS +: USER_BITS]  = mem_q[rptr_q];

    // Beat under assembly with the incoming word dropped into its slot.
    always_comb begin
      beat_s = gather_q;
      beat_s[idx_q*PAYLOAD_BITS +: PAYLOAD_BITS] = word_s;
    end

    // Next-state for word index, partial beat and FIFO bookkeeping.
    always_comb begin
      idx_d    = idx_q;
      gather_d = gather_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
        idx_d    = {IDX_W{1'b0}};
        gather_d = {USER_BITS{1'b0}};
        wptr_d   = {PTR_W{1'b0}};
        rptr_d   = {PTR_W{1'b0}};
        cnt_d    = {CNT_W{1'b0}};
      end else begin
        if (acc_s) begin
          if (last_s) begin
            idx_d = {IDX_W{1'b0}};
          end else begin
            idx_d    = idx_q + 1'b1;
            gather_d = beat_s;
          end
        end else begin
          idx_d = idx_q;
        end
        if (push_s) begin
          wptr_d = wptr_q + 1'b1;
        end else begin
          wptr_d = wptr_q;
        end
        if (pop_s) begin
          rptr_d = rptr_q + 1'b1;
        end else begin
          rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
          2'b10:   cnt_d = cnt_q + 1'b1;
          2'b01:   cnt_d = cnt_q - 1'b1;
          default: cnt_d = cnt_q;
        endcase
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        idx_q    <= {IDX_W{1'b0}};
        gather_q <= {USER_BITS{1'b0}};
        wptr_q   <= {PTR_W{1'b0}};
        rptr_q   <= {PTR_W{1'b0}};
        cnt_q    <= {CNT_W{1'b0}};
      end else begin
        idx_q    <= idx_d;
        gather_q <= gather_d;
        wptr_q   <= wptr_d;
        rptr_q   <= rptr_d;
        cnt_q    <= cnt_d;
      end
    end

    // Beat storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
      if (push_s) begin
        mem_q[wptr_q] <= beat_s;
      end
    end
  end

  // --------------------------------------------------------------- scatter
  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
    logic [IDX_W-1:0]     sidx_q, sidx_d;
    logic [USER_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [USER_BITS-1:0] head_s;
    logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 full_s, empty_s, last_s, rdy_s, push_s, wacc_s, pop_s;

    assign full_s  = (cnt_q == CNT_FULL);
    assign empty_s = (cnt_q == {CNT_W{1'b0}});
    assign last_s  = (sidx_q == IDX_LAST);
    assign rdy_s   = ~reset & ~full_s;
    assign push_s  = user_out_tvalid[j] & rdy_s & ~flush;
    assign wacc_s  = ~empty_s & ack_interface2user[j] & ~flush;
    // The head beat leaves only once its final word has been taken.
    assign pop_s   = wacc_s & last_s;
    assign head_s  = mem_q[rptr_q];

    assign user_out_tready[j]                                   = rdy_s;
    assign vld_user2interface[j]                                = ~empty_s;
    assign din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS] =
      head_s[sidx_q*PAYLOAD_BITS +: PAYLOAD_BITS];

    // Next-state for word index and FIFO bookkeeping.
    always_comb begin
      sidx_d = sidx_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
        sidx_d = {IDX_W{1'b0}};
        wptr_d = {PTR_W{1'b0}};
        rptr_d = {PTR_W{1'b0}};
        cnt_d  = {CNT_W{1'b0}};
      end else begin
        if (wacc_s) begin
          if (last_s) begin
            sidx_d = {IDX_W{1'b0}};
            rptr_d = rptr_q + 1'b1;
          end else begin
            sidx_d = sidx_q + 1'b1;
          end
        end else begin
          sidx_d = sidx_q;
        end
        if (push_s) begin
          wptr_d = wptr_q + 1'b1;
        end else begin
          wptr_d = wptr_q;
        end
        case ({push_s, pop_s})
          2'b10:   cnt_d = cnt_q + 1'b1;
          2'b01:   cnt_d = cnt_q - 1'b1;
          default: cnt_d = cnt_q;
        endcase
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sidx_q <= {IDX_W{1'b0}};
        wptr_q <= {PTR_W{1'b0}};
        rptr_q <= {PTR_W{1'b0}};
        cnt_q  <= {CNT_W{1'b0}};
      end else begin
        sidx_q <= sidx_d;
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    // Beat storage.
    always_ff @(posedge clk) begin
      if (push_s) begin
        mem_q[wptr_q] <= user_out_tdata[j*USER_BITS +: USER_BITS];
      end
    end
  end

endmodule

// File: doc/leaf_port_bridge.md
Name: leaf_port_bridge

Overview:
Per-page adapter between the leaf_interface user-side ports (vld/ack, PAYLOAD_BITS wide) and an HLS kernel's AXI-stream ports. It generalises the fixed single-port, 32-bit direct hookup to NUM_IN_PORTS/NUM_OUT_PORTS channels. Each channel adds a FIFO_DEPTH buffer. Each channel also does width conversion: it gathers or scatters USER_WORDS payload words per kernel beat. It is instantiated inside leaf_N wrappers, between leaf_interface and the kernel.

Parameters:
PAYLOAD_BITS, 32, width of one leaf_interface word
USER_WORDS, 1, payload words per kernel beat; USER_BITS = PAYLOAD_BITS*USER_WORDS
NUM_IN_PORTS, 1, BFT-to-kernel channels
NUM_OUT_PORTS, 1, kernel-to-BFT channels
FIFO_DEPTH, 4, kernel beats buffered per channel; power of 2, >=2

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
dout_leaf_interface2user  in  NUM_IN_PORTS*PAYLOAD_BITS  words from leaf_interface; channel i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
vld_interface2user  in  NUM_IN_PORTS  word valid per channel
ack_user2interface  out  NUM_IN_PORTS  word accept per channel
din_leaf_user2interface  out  NUM_OUT_PORTS*PAYLOAD_BITS  words to leaf_interface
vld_user2interface  out  NUM_OUT_PORTS  word valid
ack_interface2user  in  NUM_OUT_PORTS  word accept
user_in_tdata  out  NUM_IN_PORTS*USER_BITS  kernel input beats
user_in_tvalid  out  NUM_IN_PORTS
user_in_tready  in  NUM_IN_PORTS
user_out_tdata  in  NUM_OUT_PORTS*USER_BITS  kernel output beats
user_out_tvalid  in  NUM_OUT_PORTS
user_out_tready  out  NUM_OUT_PORTS
flush  in  1  synchronous clear of all channel state

Behaviour:
- Transfer rules: a word transfers on a cycle where vld && ack. A beat transfers on a cycle where tvalid && tready. There is no combinational path from any ready/ack input to any ready/ack output.
- Reset (async, active-high): all word indices, FIFO pointers and counts are 0. While reset is high:
  - user_in_tvalid, vld_user2interface = 0;
  - ack_user2interface, user_out_tready = 0 (forced).
  - After release, these outputs follow the rules below. Because all FIFOs are empty, acks and treadies read 1 on the first cycle.
- Input channel i (gather):
  - Word index idx runs 0..USER_WORDS-1. An accepted word is written to slot idx of the gather register, LSB-first (word 0 in bits [PAYLOAD_BITS-1:0]).
  - ack_user2interface[i] = (idx != USER_WORDS-1) || !fifo_full[i], using registered full only.
  - On acceptance of the word with idx = USER_WORDS-1, the assembled beat is pushed to the FIFO and idx returns to 0. Otherwise idx increments.
  - user_in_tvalid[i] = !fifo_empty[i]; user_in_tdata[i] = FIFO head.
  - Latency: a beat is visible 1 cycle after its last word is accepted.
  - Push and pop in the same cycle on a full FIFO: full is evaluated on registered state, so the push is refused (ack was 0). Push and pop on a non-full FIFO: count is unchanged.
  - USER_WORDS = 1: idx is constant 0 and ack = !full.
- Output channel j (scatter):
  - user_out_tready[j] = !fifo_full[j]. A beat accepted on tvalid && tready is pushed.
  - vld_user2interface[j] = !fifo_empty[j]. din_leaf_user2interface[j] = word sidx of the FIFO head.
  - On word acceptance: if sidx = USER_WORDS-1, pop and set sidx to 0; else increment sidx.
  - Latency: the first word appears 1 cycle after beat acceptance. Words go out in order 0..USER_WORDS-1 with no bubbles while ack stays 1.
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH) bits, wrapping naturally. count is log2(FIFO_DEPTH)+1 bits. full = (count == FIFO_DEPTH); empty = (count == 0).
- flush (synchronous, 1 cycle):
  - clears all idx/sidx, partial gather data, FIFO pointers and counts;
  - any handshake in the flush cycle is discarded;
  - outputs show the empty state on the next cycle.
- Channels are fully independent. Stalling one channel never affects another.
- Asserting reset mid-packet discards partial and buffered data. No stale word may appear after reset.

Test Plan:
- Single word, USER_WORDS=2: send words 0x11111111 then 0x22222222 with user_in_tready=1 -> user_in_tdata=0x2222222211111111 with tvalid high for 1 cycle, appearing 1 cycle after the second ack.
- Input backpressure, FIFO_DEPTH=4, USER_WORDS=1: hold user_in_tready=0 and offer 6 words -> 4 accepted, then ack=0. Release tready -> data 0..3 delivered in order, then words 4 and 5.
- Scatter, USER_WORDS=2: push beat 0xAAAAAAAABBBBBBBB with ack_interface2user toggling 1,0,1 -> words 0xBBBBBBBB then 0xAAAAAAAA. The FIFO pops only after the second word is acked.
- Full-FIFO edge on the output channel: fill to 4 beats, then in one cycle assert user_out_tvalid and ack the final word of the head -> push refused (tready=0 that cycle), count = 3 next cycle.
- Flush mid-gather, USER_WORDS=4: accept 2 words, pulse flush, then send 4 new words -> the delivered beat contains only the new words.
- Async reset mid-stream with NUM_IN_PORTS=2, one channel stalled: assert reset between clock edges -> tvalid/vld fall immediately and acks read 0. After release, counts are 0 and no stale data is delivered.
